// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB4 master; one APB transfer in flight, 3-cycle minimum handshake-to-response.
// Backpressure: each AXI channel stalls while its one-entry slot is full; B/R hold until accepted.
module axil_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                      axilite_clk,
  input  logic                      axilite_rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [ADDR_WIDTH-1:0]     m_apb_paddr,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [DATA_WIDTH-1:0]     m_apb_pwdata,
  output logic [DATA_WIDTH/8-1:0]   m_apb_pstrb,
  output logic [2:0]                m_apb_pprot,
  input  logic [DATA_WIDTH-1:0]     m_apb_prdata,
  input  logic                      m_apb_pready,
  input  logic                      m_apb_pslverr
);

  localparam int SW      = DATA_WIDTH / 8;
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
  } a_slot_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         strb;
  } w_slot_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  prio_wr_q, prio_wr_d;
  logic                  is_rd_q, is_rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  a_slot_t               aw_q, aw_d, ar_q, ar_d;
  w_slot_t               w_q, w_d;
  logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs, w_hs, ar_hs, wr_pend, rd_pend, grant_wr, grant_rd;
  a_slot_t               aw_in, ar_in, aw_sel, ar_sel;
  w_slot_t               w_in, w_sel;
  logic [1:0]            apb_resp;

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    is_rd_d   = is_rd_q;
    cnt_d     = cnt_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    ar_full_d = ar_full_q;
    aw_d      = aw_q;
    w_d       = w_q;
    ar_d      = ar_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    apb_resp  = m_apb_pslverr ? 2'b10 : 2'b00;

    aw_hs = s_axil_awvalid & awready_q;
    w_hs  = s_axil_wvalid & wready_q;
    ar_hs = s_axil_arvalid & arready_q;
    aw_in = '{addr: s_axil_awaddr, prot: s_axil_awprot};
    w_in  = '{data: s_axil_wdata, strb: s_axil_wstrb};
    ar_in = '{addr: s_axil_araddr, prot: s_axil_arprot};

    // A beat handshaking this cycle counts as pending so IDLE can grant without a bubble.
    aw_sel  = aw_full_q ? aw_q : aw_in;
    w_sel   = w_full_q ? w_q : w_in;
    ar_sel  = ar_full_q ? ar_q : ar_in;
    wr_pend = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    rd_pend = ar_full_q | ar_hs;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_d      = aw_in;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_d      = w_in;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_d      = ar_in;
    end

    case (state_q)
      IDLE: begin
        grant_wr = wr_pend & (~rd_pend | prio_wr_q);
        grant_rd = rd_pend & ~grant_wr;
        if (grant_wr) begin
          state_d   = SETUP;
          is_rd_d   = 1'b0;
          prio_wr_d = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          paddr_d   = aw_sel.addr;
          pprot_d   = aw_sel.prot;
          pwrite_d  = 1'b1;
          pwdata_d  = w_sel.data;
          pstrb_d   = w_sel.strb;
        end else if (grant_rd) begin
          state_d   = SETUP;
          is_rd_d   = 1'b1;
          prio_wr_d = 1'b1;
          ar_full_d = 1'b0;
          paddr_d   = ar_sel.addr;
          pprot_d   = ar_sel.prot;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          pstrb_d   = '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (m_apb_pready) begin
          state_d = RESP;
          if (is_rd_q) begin
            rresp_d = apb_resp;
            rdata_d = m_apb_prdata;
          end else begin
            bresp_d = apb_resp;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TO_LAST))) begin
          state_d = RESP;
          if (is_rd_q) begin
            rresp_d = 2'b10;
            rdata_d = '0;
          end else begin
            bresp_d = 2'b10;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (is_rd_q ? s_axil_rready : s_axil_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    bvalid_d  = (state_d == RESP) && !is_rd_d;
    rvalid_d  = (state_d == RESP) && is_rd_d;
    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
    arready_d = ~ar_full_d;
  end

  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      is_rd_q   <= 1'b0;
      cnt_q     <= '0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_q      <= '0;
      w_q       <= '0;
      ar_q      <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      is_rd_q   <= is_rd_d;
      cnt_q     <= cnt_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      aw_q      <= aw_d;
      w_q       <= w_d;
      ar_q      <= ar_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_arready = arready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign m_apb_paddr    = paddr_q;
  assign m_apb_psel     = psel_q;
  assign m_apb_penable  = penable_q;
  assign m_apb_pwrite   = pwrite_q;
  assign m_apb_pwdata   = pwdata_q;
  assign m_apb_pstrb    = pstrb_q;
  assign m_apb_pprot    = pprot_q;

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Bench for axil_apb_bridge: scripted AXI master, scripted APB slave, response scoreboard.
module tb_axil_apb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready = 1'b1, pslverr = 1'b0, prdata_fn = 1'b0;
  logic [31:0] prdata_val = '0;

  localparam logic [31:0] KEY = 32'h5A5A_0000;
  assign prdata = prdata_fn ? (paddr ^ KEY) : prdata_val;

  typedef struct packed { logic rd; logic [31:0] data; logic [1:0] resp; } exp_t;
  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdata; } apb_t;
  exp_t sb[$];
  apb_t apb_log[$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .axilite_clk(clk), .axilite_rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .m_apb_paddr(paddr), .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
    .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb), .m_apb_pprot(pprot),
    .m_apb_prdata(prdata), .m_apb_pready(pready), .m_apb_pslverr(pslverr)
  );

  always @(negedge clk) begin
    if (psel && !penable) apb_log.push_back('{wr: pwrite, addr: paddr, wdata: pwdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awprot = 3'b000; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic drive_read(input logic [31:0] a);
    araddr = a; arprot = 3'b001; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_resp(output logic is_rd, output logic [31:0] d, output logic [1:0] r, output bit ok);
    ok = 1'b0; is_rd = 1'b0; d = '0; r = '0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bvalid) begin
        is_rd = 1'b0; r = bresp; ok = 1'b1;
      end else if (rvalid) begin
        is_rd = 1'b1; r = rresp; d = rdata; ok = 1'b1;
      end
      tick();
    end
    bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] sig;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++; $display("FAIL reset_readies: got %b, want 000", {awready, wready, arready});
    end
    sig = {psel, penable, pwrite, bvalid, rvalid, bresp, rresp, pstrb, pprot};
    total++;
    if (sig !== 32'h0 || paddr !== 32'h0 || pwdata !== 32'h0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_outputs: got ctl=%h paddr=%h pwdata=%h rdata=%h, want all 0", sig, paddr, pwdata, rdata);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL reset_release_readies: got %b, want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_single_write();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
    sb.push_back('{rd: 1'b0, data: 32'h0, resp: 2'b00});
    drive_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    total++;
    if (!(psel === 1'b1 && penable === 1'b0 && paddr === 32'h10 && pwrite === 1'b1 &&
          pstrb === 4'hF && pwdata === 32'hDEAD_BEEF && pprot === 3'b000)) begin
      bad++; $display("FAIL sw_setup: got psel=%b pen=%b paddr=%h pwrite=%b pstrb=%h pwdata=%h, want 1 0 10 1 f deadbeef",
                      psel, penable, paddr, pwrite, pstrb, pwdata);
    end
    tick();
    total++;
    if (!(psel === 1'b1 && penable === 1'b1 && paddr === 32'h10 && pwdata === 32'hDEAD_BEEF)) begin
      bad++; $display("FAIL sw_access: got psel=%b pen=%b paddr=%h, want 1 1 10", psel, penable, paddr);
    end
    tick();
    total++;
    if (!(bvalid === 1'b1 && psel === 1'b0 && penable === 1'b0)) begin
      bad++; $display("FAIL sw_bvalid_cycle3: got bvalid=%b psel=%b, want bvalid=1 psel=0", bvalid, psel);
    end
    wait_resp(is_rd, d, r, ok);
    e = sb.pop_front();
    total++;
    if (!ok || is_rd !== e.rd || r !== e.resp) begin
      bad++; $display("FAIL sw_resp: got ok=%0d rd=%b resp=%b, want rd=%b resp=%b", ok, is_rd, r, e.rd, e.resp);
    end
    total++;
    if (bvalid !== 1'b0) begin
      bad++; $display("FAIL sw_bvalid_drop: got %b, want 0", bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
    wdata = 32'h0BAD_F00D; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    total++;
    if (wready !== 1'b0 || awready !== 1'b1 || psel !== 1'b0) begin
      bad++; $display("FAIL wfirst_wready_drop: got wready=%b awready=%b psel=%b, want 0 1 0", wready, awready, psel);
    end
    tick();
    awaddr = 32'h40; awprot = 3'b010; awvalid = 1'b1;
    sb.push_back('{rd: 1'b0, data: 32'h0, resp: 2'b00});
    total++;
    if (psel !== 1'b0) begin
      bad++; $display("FAIL wfirst_early_start: got psel=%b, want 0", psel);
    end
    tick();
    awvalid = 1'b0;
    total++;
    if (!(psel === 1'b1 && penable === 1'b0 && paddr === 32'h40 && pwdata === 32'h0BAD_F00D &&
          pstrb === 4'h3 && pprot === 3'b010 && wready === 1'b1)) begin
      bad++; $display("FAIL wfirst_setup: got psel=%b paddr=%h pwdata=%h pstrb=%h pprot=%b wready=%b, want 1 40 0badf00d 3 010 1",
                      psel, paddr, pwdata, pstrb, pprot, wready);
    end
    wait_resp(is_rd, d, r, ok);
    e = sb.pop_front();
    total++;
    if (!ok || is_rd !== e.rd || r !== e.resp) begin
      bad++; $display("FAIL wfirst_resp: got ok=%0d rd=%b resp=%b, want rd=%b resp=%b", ok, is_rd, r, e.rd, e.resp);
    end
  endtask

  task automatic test_read_wait();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e; int unstable;
    prdata_fn = 1'b0; prdata_val = 32'hFFFF_0000; pready = 1'b0; unstable = 0;
    sb.push_back('{rd: 1'b1, data: 32'h1234_5678, resp: 2'b00});
    drive_read(32'h24);
    total++;
    if (!(psel === 1'b1 && penable === 1'b0 && paddr === 32'h24 && pwrite === 1'b0 &&
          pwdata === 32'h0 && pstrb === 4'h0 && pprot === 3'b001)) begin
      bad++; $display("FAIL rd_setup: got psel=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h, want 1 24 0 0 0",
                      psel, paddr, pwrite, pwdata, pstrb);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!(psel === 1'b1 && penable === 1'b1 && paddr === 32'h24 && pwrite === 1'b0)) unstable++;
    end
    pready = 1'b1; prdata_val = 32'h1234_5678;
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL rd_access_stable: got %0d unstable cycles, want 0", unstable);
    end
    tick();
    total++;
    if (rvalid !== 1'b1 || psel !== 1'b0) begin
      bad++; $display("FAIL rd_rvalid_cycle6: got rvalid=%b psel=%b, want 1 0", rvalid, psel);
    end
    prdata_val = 32'h0;
    wait_resp(is_rd, d, r, ok);
    e = sb.pop_front();
    total++;
    if (!ok || is_rd !== e.rd || r !== e.resp || d !== e.data) begin
      bad++; $display("FAIL rd_resp: got ok=%0d rd=%b resp=%b data=%h, want rd=%b resp=%b data=%h",
                      ok, is_rd, r, d, e.rd, e.resp, e.data);
    end
  endtask

  task automatic test_slverr_write();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
    pslverr = 1'b1;
    sb.push_back('{rd: 1'b0, data: 32'h0, resp: 2'b10});
    drive_write(32'h80, 32'hA0A0_A0A0, 4'h1);
    wait_resp(is_rd, d, r, ok);
    pslverr = 1'b0;
    e = sb.pop_front();
    total++;
    if (!ok || is_rd !== e.rd || r !== e.resp) begin
      bad++; $display("FAIL slverr_bresp: got ok=%0d rd=%b resp=%b, want rd=%b resp=%b", ok, is_rd, r, e.rd, e.resp);
    end
  endtask

  task automatic test_timeout_read();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e; int n;
    pready = 1'b0; prdata_fn = 1'b0; prdata_val = 32'hFFFF_FFFF; n = 0;
    sb.push_back('{rd: 1'b1, data: 32'h0, resp: 2'b10});
    drive_read(32'h58);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (psel && penable) n++;
      else break;
    end
    total++;
    if (n != 8) begin
      bad++; $display("FAIL timeout_access_cycles: got %0d, want 8", n);
    end
    wait_resp(is_rd, d, r, ok);
    pready = 1'b1; prdata_val = 32'h0;
    e = sb.pop_front();
    total++;
    if (!ok || is_rd !== e.rd || r !== e.resp || d !== e.data) begin
      bad++; $display("FAIL timeout_resp: got ok=%0d rd=%b resp=%b data=%h, want rd=%b resp=%b data=%h",
                      ok, is_rd, r, d, e.rd, e.resp, e.data);
    end
  endtask

  task automatic test_arbitration();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
    logic [31:0] wa, ra, wd;
    prdata_fn = 1'b1;
    apb_log.delete();
    for (int k = 0; k < 4; k++) begin
      wa = 32'h100 + 32'(k * 16); ra = 32'h200 + 32'(k * 16); wd = 32'hC0DE_0000 + 32'(k);
      awaddr = wa; awprot = 3'b000; awvalid = 1'b1;
      wdata = wd; wstrb = 4'hF; wvalid = 1'b1;
      araddr = ra; arprot = 3'b001; arvalid = 1'b1;
      sb.push_back('{rd: 1'b0, data: 32'h0, resp: 2'b00});
      sb.push_back('{rd: 1'b1, data: ra ^ KEY, resp: 2'b00});
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int j = 0; j < 2; j++) begin
        wait_resp(is_rd, d, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || is_rd !== e.rd || r !== e.resp || (e.rd && d !== e.data)) begin
          bad++; $display("FAIL arb_resp[%0d.%0d]: got ok=%0d rd=%b resp=%b data=%h, want rd=%b resp=%b data=%h",
                          k, j, ok, is_rd, r, d, e.rd, e.resp, e.data);
        end
      end
    end
    prdata_fn = 1'b0;
    total++;
    if (apb_log.size() != 8) begin
      bad++; $display("FAIL arb_count: got %0d APB transfers, want 8", apb_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        wa = (i % 2 == 0) ? (32'h100 + 32'((i / 2) * 16)) : (32'h200 + 32'((i / 2) * 16));
        wd = (i % 2 == 0) ? (32'hC0DE_0000 + 32'(i / 2)) : 32'h0;
        total++;
        if (apb_log[i].wr !== (i % 2 == 0) || apb_log[i].addr !== wa || apb_log[i].wdata !== wd) begin
          bad++; $display("FAIL arb_order[%0d]: got wr=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                          i, apb_log[i].wr, apb_log[i].addr, apb_log[i].wdata, (i % 2 == 0), wa, wd);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic is_rd; logic [31:0] d; logic [1:0] r; bit ok; exp_t e; int stray;
    pready = 1'b0; bready = 1'b0; stray = 0;
    drive_write(32'h300, 32'h1111_2222, 4'hF);
    tick();
    total++;
    if (!(psel === 1'b1 && penable === 1'b1)) begin
      bad++; $display("FAIL rmid_in_access: got psel=%b pen=%b, want 1 1", psel, penable);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (!(psel === 1'b0 && penable === 1'b0 && bvalid === 1'b0 && paddr === 32'h0 && awready === 1'b0)) begin
      bad++; $display("FAIL rmid_reset_state: got psel=%b pen=%b bvalid=%b paddr=%h awready=%b, want 0 0 0 0 0",
                      psel, penable, bvalid, paddr, awready);
    end
    pready = 1'b1;
    tick();
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL rmid_readies: got %b, want 111", {awready, wready, arready});
    end
    for (int i = 0; i < 5; i++) begin
      if (bvalid || rvalid || psel) stray++;
      tick();
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL rmid_no_stale: got %0d cycles of activity, want 0", stray);
    end
    sb.push_back('{rd: 1'b0, data: 32'h0, resp: 2'b00});
    drive_write(32'h304, 32'h3333_4444, 4'hC);
    total++;
    if (!(psel === 1'b1 && paddr === 32'h304 && pwdata === 32'h3333_4444 && pstrb === 4'hC)) begin
      bad++; $display("FAIL rmid_next_setup: got psel=%b paddr=%h pwdata=%h pstrb=%h, want 1 304 33334444 c",
                      psel, paddr, pwdata, pstrb);
    end
    wait_resp(is_rd, d, r, ok);
    e = sb.pop_front();
    total++;
    if (!ok || is_rd !== e.rd || r !== e.resp) begin
      bad++; $display("FAIL rmid_next_resp: got ok=%0d rd=%b resp=%b, want rd=%b resp=%b", ok, is_rd, r, e.rd, e.resp);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_read_wait();
    test_slverr_write();
    test_timeout_read();
    test_arbitration();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_apb_bridge.md
# axil_apb_bridge

AXI4-Lite slave to APB4 master bridge, the front stage of the register-map path. It accepts CPU AXI4-Lite reads and writes, runs one APB4 transfer at a time with full PREADY wait-state and PSLVERR support plus a timeout, and returns the AXI response. Its APB master port feeds the register-file decode stage directly, replacing the vendor bridge IP in that path.

## Interface
- ADDR_WIDTH, 32, AXI/APB address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT, 256, maximum ACCESS-phase cycles without PREADY before the transfer is aborted; 0 disables the timeout.
- axilite_clk  in  1  single clock for both AXI and APB sides.
- axilite_rst  in  1  reset, synchronous, active-high.
- s_axil  AXI4Lite.slave  —  signals used: awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready.
- m_apb  APB4.master  —  signals used: paddr/psel/penable/pwrite/pwdata/pstrb/pprot out; prdata/pready/pslverr in.

## Operation
- Three independent one-entry holding slots: AW (addr, prot), W (data, strb), AR (addr, prot).
- awready, wready and arready are each high while their slot is empty.
- A slot fills on valid&ready and frees when its transfer enters SETUP.
- AW and W are accepted in either order or in the same cycle; a write is pending only when both slots are full.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if a write and a read are both pending, grant the opposite of the last grant (priority flag; reset value = write first). Otherwise grant whichever is pending. On grant, go to SETUP.
- SETUP (one cycle): psel=1, penable=0.
  - paddr, pprot and pwrite are driven from the granted slot.
  - Writes: pwdata and pstrb come from the W slot.
  - Reads: pwdata=0, pstrb=0.
  - Next state is ACCESS.
- ACCESS: psel=1, penable=1, all APB outputs held stable.
  - When pready=1: latch prdata (reads only) and pslverr, then go to RESP.
  - Timeout counter starts at 0 on entry. If it reaches TIMEOUT-1 with pready low: abort, go to RESP with error=1 and rdata=0.
- RESP:
  - Writes: bvalid=1, bresp = error ? 2'b10 : 2'b00.
  - Reads: rvalid=1, rresp likewise, rdata = latched prdata.
  - Hold until bready/rready, then go to IDLE.
- Only one APB transfer is outstanding at a time. Holding slots may refill during SETUP, ACCESS or RESP.
- prdata is ignored on writes and on error-free cycles where pready=0.

## Timing
- Reset values:
  - psel, penable, pwrite = 0; paddr, pwdata, pstrb, pprot = 0.
  - bvalid, rvalid = 0; bresp, rresp, rdata = 0.
  - awready, wready, arready = 0 while axilite_rst is high; all three are 1 in the first cycle after reset deasserts.
  - FSM = IDLE; priority = write.
- Minimum write latency, with AW and W handshaking in cycle 0 and pready=1:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - bvalid first high in cycle 3.
- Read minimum latency is the same: arvalid handshake in cycle 0 gives rvalid in cycle 3.
- Each cycle of pready=0 in ACCESS adds one cycle.
- A transfer aborted by timeout spends exactly TIMEOUT cycles in ACCESS.
- Reset asserted mid-transfer: the next cycle is IDLE with all outputs at reset values. The in-flight transfer and slot contents are discarded, and no response is issued.
- All APB and AXI outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single write: awaddr=0x0000_0010 and wdata=0xDEAD_BEEF with wstrb=0xF in the same cycle, pready=1 -> one SETUP then one ACCESS with paddr=0x10, pwrite=1, pstrb=0xF; bvalid in cycle 3 with bresp=0.
- W before AW: wvalid 2 cycles before awvalid -> wready drops after W is accepted; transfer starts the cycle after the AW handshake; correct pwdata.
- Read with wait states: araddr=0x24, pready low for 3 ACCESS cycles, then prdata=0x1234_5678 -> rvalid after 6 cycles, rdata=0x1234_5678, rresp=0; paddr stable throughout.
- Error and timeout:
  - pslverr=1 on a write -> bresp=2'b10.
  - TIMEOUT=8 with pready held 0 on a read -> psel drops after 8 ACCESS cycles; rresp=2'b10, rdata=0.
- Arbitration: read and write pending in the same IDLE cycle, repeated 4 times -> APB order W,R,W,R; responses match their requests.
- Reset mid-ACCESS with bready held 0 -> psel=0 and bvalid=0 next cycle, readies return to 1; a following write completes normally.
